// File: rtl/load_align_unit_pkg.sv
// Shared MEM-stage definitions: load/store funct3 encodings and the load unit state.
package load_align_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lau_state_e;

endpackage

// File: rtl/load_align_unit_extract.sv
// Combinational lane select and sign/zero extension of a 32-bit memory read word.
module load_extract
    import load_align_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        // Halfword lane comes from addr_lo[1] only; a set addr_lo[0] is just flagged.
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        data       = rdata;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: data = {24'd0, byte_sel};
            F3_LH: begin
                data       = {{16{half_sel[15]}}, half_sel};
                misaligned = addr_lo[0];
            end
            F3_LHU: begin
                data       = {16'd0, half_sel};
                misaligned = addr_lo[0];
            end
            F3_LW: begin
                data       = rdata;
                misaligned = (addr_lo != 2'd0);
            end
            default: begin
                data       = rdata;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// MEM-stage load unit: accepts a load, waits the memory read latency, and presents
// the aligned, extended result with its destination register until WB consumes it.
module load_align_unit
    import load_align_unit_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [4:0]  rd_addr,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] dm_rdata,
    output logic        busy,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic [4:0]  load_rd,
    output logic        misaligned
);

    localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY - 1);

    lau_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  alo_q, alo_d;
    logic [4:0]  req_rd_q, req_rd_d;
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  rd_q, rd_d;
    logic        mis_q, mis_d;

    logic [31:0] ext_data;
    logic        ext_mis;

    load_extract u_extract (
        .funct3     (f3_q),
        .addr_lo    (alo_q),
        .rdata      (dm_rdata),
        .data       (ext_data),
        .misaligned (ext_mis)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        alo_d    = alo_q;
        req_rd_d = req_rd_q;
        valid_d  = valid_q;
        data_d   = data_q;
        rd_d     = rd_q;
        mis_d    = mis_q;

        if (flush) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MemRead) begin
                        f3_d     = funct3;
                        alo_d    = addr_lo;
                        req_rd_d = rd_addr;
                        cnt_d    = LAT_INIT;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != 2'd0) begin
                        cnt_d = cnt_q - 2'd1;
                    end else begin
                        data_d  = ext_data;
                        rd_d    = req_rd_q;
                        mis_d   = ext_mis;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    // The result is consumed on any non-stalled DONE cycle; a new
                    // request can be accepted in that same cycle.
                    if (!stall) begin
                        valid_d = 1'b0;
                        if (MemRead) begin
                            f3_d     = funct3;
                            alo_d    = addr_lo;
                            req_rd_d = rd_addr;
                            cnt_d    = LAT_INIT;
                            state_d  = WAIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            f3_q     <= 3'd0;
            alo_q    <= 2'd0;
            req_rd_q <= 5'd0;
            valid_q  <= 1'b0;
            data_q   <= 32'd0;
            rd_q     <= 5'd0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            alo_q    <= alo_d;
            req_rd_q <= req_rd_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            rd_q     <= rd_d;
            mis_q    <= mis_d;
        end
    end

    assign busy       = (state_q == WAIT) || ((state_q == DONE) && stall);
    assign load_valid = valid_q;
    assign load_data  = data_q;
    assign load_rd    = rd_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Randomized and directed bench for load_align_unit against a transaction-level model.
// Handshake: a request is taken on a clock edge where MemRead=1, busy=0 and flush=0;
// a result is consumed on an edge where load_valid=1 and stall=0 (flush/rst kill it).
module tb_load_align_unit;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst, mem_read, stall, flush;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic [4:0]  rd_addr;
  logic [31:0] dm_rdata, req_word;
  logic        busy, load_valid, misaligned;
  logic [31:0] load_data;
  logic [4:0]  load_rd;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 0;

  // model state: one request waiting on memory, or one result presented
  logic [37:0] exp_q[$];
  bit          pending, presenting;
  int          age;
  logic [31:0] pend_word;

  load_align_unit #(.RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .MemRead(mem_read), .funct3(funct3), .addr_lo(addr_lo),
    .rd_addr(rd_addr), .stall(stall), .flush(flush), .dm_rdata(dm_rdata),
    .busy(busy), .load_valid(load_valid), .load_data(load_data), .load_rd(load_rd),
    .misaligned(misaligned)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // reference: {rd, misaligned, data} computed from plain arithmetic on the word
  function automatic logic [37:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [4:0] r, input logic [31:0] w);
    int unsigned b, h, d;
    bit m;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    m = 0;
    case (f3)
      3'd0: d = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4: d = b;
      3'd1: begin d = (h >= 32768) ? h + 32'hFFFF_0000 : h; m = (a % 2) != 0; end
      3'd5: begin d = h; m = (a % 2) != 0; end
      3'd2: begin d = w; m = (a != 0); end
      default: d = w;
    endcase
    return {r, m, d[31:0]};
  endfunction

  // memory model + scoreboard monitor (samples on the falling edge)
  always @(negedge clk) begin
    logic [37:0] e;
    bit m_busy, acc;
    dm_rdata = (pending && age == LAT) ? pend_word : $urandom();
    m_busy = pending || (presenting && stall);
    if (mon_en) begin
      chk("load_valid", {31'd0, load_valid}, {31'd0, presenting});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      if (presenting) begin
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          chk("sb_data", load_data, e[31:0]);
          chk("sb_rd", {27'd0, load_rd}, {27'd0, e[37:33]});
          chk("sb_misaligned", {31'd0, misaligned}, {31'd0, e[32]});
        end else begin
          chk("sb_empty", 32'd0, 32'd1);
        end
      end
    end
    if (rst || flush) begin
      pending = 0; presenting = 0; age = 0;
      exp_q.delete();
    end else begin
      acc = mem_read && !m_busy;
      if (presenting && !stall) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        presenting = 0;
      end
      if (pending) begin
        if (age == LAT) begin pending = 0; presenting = 1; age = 0; end
        else age++;
      end
      if (acc) begin
        pending = 1; age = 1; pend_word = req_word;
        exp_q.push_back(ref_load(funct3, addr_lo, rd_addr, req_word));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [1:0] a, input logic [4:0] r,
                       input logic [31:0] w);
    mem_read = 1'b1; funct3 = f3; addr_lo = a; rd_addr = r; req_word = w;
    step();
    mem_read = 1'b0;
  endtask

  // returns the cycle index (acceptance cycle = 0) where load_valid is seen
  task automatic wait_valid(output int n);
    n = 1;
    while (load_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) chk("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; mem_read = 1'b0; stall = 1'b0; flush = 1'b0;
    funct3 = 3'd0; addr_lo = 2'd0; rd_addr = 5'd0; req_word = 32'd0;
    pending = 0; presenting = 0; age = 0;
    step(); step();
    mon_en = 1;
    step();
    rst = 1'b0;
    chk("rst_valid", {31'd0, load_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data", load_data, 32'd0);
    chk("rst_rd", {27'd0, load_rd}, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);

    // LB sign-extended top byte, latency
    issue(3'b000, 2'b11, 5'd1, 32'h80FF_1234);
    wait_valid(n);
    chk("lb_latency", n, LAT + 1);
    chk("lb_data", load_data, 32'hFFFF_FF80);
    chk("lb_mis", {31'd0, misaligned}, 32'd0);
    step();

    // LHU upper half, LH misaligned
    issue(3'b101, 2'b10, 5'd2, 32'h8001_7F00);
    wait_valid(n);
    chk("lhu_data", load_data, 32'h0000_8001);
    step();
    issue(3'b001, 2'b01, 5'd3, 32'h8001_7F00);
    wait_valid(n);
    chk("lh_data", load_data, 32'h0000_7F00);
    chk("lh_mis", {31'd0, misaligned}, 32'd1);
    step();

    // LW held under stall
    stall = 1'b1;
    issue(3'b010, 2'b00, 5'd4, 32'hDEAD_BEEF);
    wait_valid(n);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", {31'd0, load_valid}, 32'd1);
      chk("stall_data", load_data, 32'hDEAD_BEEF);
      chk("stall_rd", {27'd0, load_rd}, 32'd4);
      chk("stall_busy", {31'd0, busy}, 32'd1);
    end
    stall = 1'b0;
    step();
    chk("stall_release", {31'd0, load_valid}, 32'd0);

    // back-to-back: new request in the consuming DONE cycle
    issue(3'b100, 2'b00, 5'd5, 32'h1234_56A5);
    wait_valid(n);
    chk("b2b_first_rd", {27'd0, load_rd}, 32'd5);
    chk("b2b_first_data", load_data, 32'h0000_00A5);
    issue(3'b010, 2'b00, 5'd6, 32'h1357_9BDF);
    chk("b2b_bubble", {31'd0, load_valid}, 32'd0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_valid(n);
    chk("b2b_second_rd", {27'd0, load_rd}, 32'd6);
    chk("b2b_second_data", load_data, 32'h1357_9BDF);
    step();

    // flush while waiting on memory
    issue(3'b010, 2'b00, 5'd7, 32'hCAFE_F00D);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_valid", {31'd0, load_valid}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("flush_no_valid", {31'd0, load_valid}, 32'd0);
    end
    issue(3'b000, 2'b01, 5'd8, 32'h0000_7F00);
    wait_valid(n);
    chk("post_flush_data", load_data, 32'h0000_007F);
    step();

    // reset while presenting a stalled result
    stall = 1'b1;
    issue(3'b010, 2'b00, 5'd9, 32'h5555_AAAA);
    wait_valid(n);
    rst = 1'b1;
    step();
    rst = 1'b0;
    stall = 1'b0;
    chk("rst_done_valid", {31'd0, load_valid}, 32'd0);
    chk("rst_done_data", load_data, 32'd0);
    chk("rst_done_rd", {27'd0, load_rd}, 32'd0);
    chk("rst_done_busy", {31'd0, busy}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      mem_read = ($urandom_range(0, 99) < 60);
      stall    = ($urandom_range(0, 99) < 25);
      flush    = ($urandom_range(0, 99) < 3);
      rst      = ($urandom_range(0, 199) == 0);
      funct3   = 3'($urandom_range(0, 7));
      addr_lo  = 2'($urandom_range(0, 3));
      rd_addr  = 5'($urandom_range(0, 31));
      req_word = $urandom();
      step();
    end

    mem_read = 1'b0; stall = 1'b0; flush = 1'b0; rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Load-side counterpart to the store formatter in the MEM stage.
- Captures a load request from the pipeline and waits the fixed data-memory read latency.
- Extracts the addressed byte, halfword or word from the 32-bit memory read word, then sign- or zero-extends it per funct3.
- Presents a registered, stall-safe result (with destination register) to the WB stage.

Parameters:
- RD_LATENCY, 1, cycles from request acceptance until dm_rdata is valid (1..4).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- MemRead  input  1  load request from the MEM stage
- funct3  input  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101
- addr_lo  input  2  effective address bits [1:0]
- rd_addr  input  5  destination register of the load
- stall  input  1  WB not ready; hold the presented result
- flush  input  1  kill the in-flight load
- dm_rdata  input  32  data-memory read word, valid RD_LATENCY cycles after acceptance
- busy  output  1  load in flight; MEM stage must not issue
- load_valid  output  1  load_data/load_rd are valid
- load_data  output  32  aligned, extended load result
- load_rd  output  5  destination register, registered with the result
- misaligned  output  1  qualified by load_valid: LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0

Behaviour:
- Reset (synchronous): state=IDLE; busy=0; load_valid=0; load_data=0; load_rd=0; misaligned=0; latency counter=0.

States:
- IDLE: MemRead=1 and flush=0 -> capture funct3, addr_lo, rd_addr; counter=RD_LATENCY-1; go WAIT.
- WAIT: busy=1.
  - counter!=0 -> decrement.
  - counter==0 -> sample dm_rdata, compute the result, register it into load_data, load_rd and misaligned; load_valid=1; go DONE.
- DONE: load_valid=1.
  - stall=1 -> hold all outputs unchanged.
  - stall=0 -> the result is consumed this cycle.
    - If MemRead=1 in the same cycle, accept the new request (back-to-back) and go WAIT. load_valid drops next cycle.
    - Otherwise go IDLE with load_valid=0.

Timing:
- Latency from acceptance to load_valid = RD_LATENCY+1 cycles.
- busy=1 in WAIT, and in DONE while stall=1.

Extraction and extension:
- LB/LBU: byte lane addr_lo (lane 0 = bits[7:0]).
- LH/LHU: halfword lane addr_lo[1]; addr_lo[0] is ignored for data selection.
- LW: full word regardless of addr_lo.
- LB/LH sign-extend; LBU/LHU zero-extend.
- Undefined funct3 (011, 110, 111): raw dm_rdata, misaligned=0.

Flush:
- flush=1 in any state -> next state IDLE, load_valid=0, busy=0; no sample is taken.
- flush has priority over MemRead and stall in the same cycle.

Other rules:
- MemRead while busy=1 (outside the DONE/stall=0 case) is ignored; upstream must hold it.
- Reset in WAIT or DONE: outputs return to reset values the next cycle; the in-flight result is discarded.
- dm_rdata is sampled only in the WAIT cycle with counter==0; other cycles are don't-care.

Decomposition:
- Shared package (alongside the store funct3 constants):
  - funct3 localparams LB/LH/LW/LBU/LHU, SB/SH/SW;
  - load-unit state enum {IDLE, WAIT, DONE}.
- One natural sub-module, load_extract: combinational lane select plus extension (funct3, addr_lo, rdata -> data, misaligned). Reused by any future bypass path.

Test Plan:
- LB, addr_lo=11, dm_rdata=0x80FF_1234, RD_LATENCY=1 -> two cycles after acceptance: load_valid=1, load_data=0xFFFF_FF80, misaligned=0.
- LHU, addr_lo=10, dm_rdata=0x8001_7F00 -> load_data=0x0000_8001. Also LH, addr_lo=01 -> load_data=0x0000_7F00, misaligned=1.
- LW, addr_lo=00, dm_rdata=0xDEAD_BEEF, with stall=1 for 3 cycles at DONE -> load_valid, load_data=0xDEAD_BEEF and load_rd held constant for all stalled cycles; released the cycle stall drops.
- Back-to-back: LBU to rd=5, then LW to rd=6 issued in the DONE cycle with stall=0 -> rd=5 result, one bubble cycle with load_valid=0, then rd=6 result; no loss or duplication.
- flush asserted in WAIT with RD_LATENCY=3 -> IDLE next cycle; load_valid never rises; busy=0; a subsequent load completes normally.
- rst pulsed in DONE while stall=1 -> next cycle load_valid=0, load_data=0, state IDLE.
